// File: rtl/msg_validity_checker.sv
// rtl/msg_validity_checker.sv - plaintext readability checker for RC4 key search
// Optional capture buffer enabled by MSG_CHECK_CAPTURE_EN.
module msg_validity_checker #(
  parameter int MSG_LEN = 32,
  parameter int IDX_W   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             success,
  output logic             failure,
  output logic [IDX_W:0]   byte_count,
  output logic [IDX_W-1:0] bad_index,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [7:0]       rd_data
);

  typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_PASS, ST_FAIL} state_t;

  localparam logic [IDX_W:0] LAST_IDX = (IDX_W+1)'(MSG_LEN - 1);
  localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(MSG_LEN);

  state_t state, state_n;
  logic   byte_ok;
  logic   accept;

  assign byte_ok = (in_data == 8'h20) || ((in_data >= 8'h61) && (in_data <= 8'h7A));
  assign accept  = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // start overrides everything, so a byte offered alongside it is never accepted
  always_comb begin
    state_n  = state;
    in_ready = (state == ST_CHECK) && !start;
    busy     = (state == ST_CHECK);
    success  = (state == ST_PASS);
    failure  = (state == ST_FAIL);
    case (state)
      ST_CHECK: begin
        if (accept) begin
          if (!byte_ok) begin
            state_n = ST_FAIL;
          end else if (byte_count == LAST_IDX) begin
            state_n = ST_PASS;
          end
        end
      end
      default: state_n = state;
    endcase
    if (start) begin
      state_n = ST_CHECK;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_count <= '0;
      bad_index  <= '0;
    end else if (start) begin
      byte_count <= '0;
    end else if (accept) begin
      if (!byte_ok) begin
        bad_index <= byte_count[IDX_W-1:0];
      end else if (byte_count != FULL_CNT) begin
        byte_count <= byte_count + 1'b1;
      end
    end
  end

`ifdef MSG_CHECK_CAPTURE_EN
  logic [7:0] buffer [MSG_LEN];

  // buffer is deliberately not reset so the last message survives a new start
  always_ff @(posedge clk) begin
    if (accept) begin
      buffer[byte_count[IDX_W-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= 8'h00;
    end else if (int'(rd_addr) < MSG_LEN) begin
      rd_data <= buffer[rd_addr];
    end else begin
      rd_data <= 8'h00;
    end
  end
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^rd_addr;
  assign rd_data        = 8'h00;
`endif

endmodule
